// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the pipeline sequencer state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memread,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu
);

  // $zero is never a real dependency, so a load targeting it cannot cause a stall.
  assign lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Per-cycle enable/flush sequencer for the five pipeline registers, including the
// halt-drain sequence and saturating stall/flush event counters.
module pipeline_stall_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dren_m,
  input  logic             dwen_m,
  input  logic             ex_memread,
  input  regbits_t         ex_rt,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             redirect_ex,
  input  logic             halt_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_ctrl_state_t state_q;
  pipe_ctrl_state_t state_d;

  logic dstall;
  logic istall;
  logic lu;
  logic redirect_apply;
  logic stall_inc;

  assign dstall = (dren_m || dwen_m) && !dhit;
  assign istall = !ihit;

  load_use_detect u_lu (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (lu)
  );

  always_comb begin
    state_d        = state_q;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    memwb_flush    = 1'b0;
    halt           = 1'b0;
    redirect_apply = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        if (dstall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (redirect_ex) begin
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          redirect_apply = 1'b1;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (istall) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end

        if (state_q == RUN) begin
          if (halt_id && !dstall && !redirect_ex && !lu) begin
            state_d = DRAIN;
          end
        end else begin
          // While draining, fetch stays frozen unless a redirect proves the HALT was wrong-path.
          if (!redirect_apply) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
          end
          // A HALT retiring in WB is older than anything in EX, so it outranks the redirect.
          if (halt_wb && memwb_en) begin
            state_d = HALTED;
          end else if (redirect_apply) begin
            state_d = RUN;
          end
        end
      end

      HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        halt     = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain cycles are intentional freezes and are not charged as stalls.
  assign stall_inc = (state_q == RUN) && !pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (redirect_apply),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; a narrow counter width exposes saturation.
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;

  logic          CLK;
  logic          RST;
  logic          ihit, dhit, dren_m, dwen_m, ex_memread;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic          redirect_ex, halt_id, halt_wb;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, memwb_flush, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0]    ctl;

  int checks   = 0;
  int failures = 0;

  // ctl = {pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flush, halt}
  localparam logic [8:0] C_ALL    = 9'b11111_000_0;
  localparam logic [8:0] C_DSTALL = 9'b00001_001_0;
  localparam logic [8:0] C_REDIR  = 9'b11111_110_0;
  localparam logic [8:0] C_LU     = 9'b00111_010_0;
  localparam logic [8:0] C_ISTALL = 9'b01111_100_0;
  localparam logic [8:0] C_DRAIN  = 9'b01111_100_0;
  localparam logic [8:0] C_HALTED = 9'b00000_000_1;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, memwb_flush, halt};

  pipeline_stall_ctrl #(.CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .dren_m      (dren_m),
    .dwen_m      (dwen_m),
    .ex_memread  (ex_memread),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .redirect_ex (redirect_ex),
    .halt_id     (halt_id),
    .halt_wb     (halt_wb),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .memwb_flush (memwb_flush),
    .halt        (halt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b1; dren_m = 1'b0; dwen_m = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    redirect_ex = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;

    // reset state
    @(negedge CLK); #1;
    chk("rst_ctl", 32'(ctl), 32'(C_ALL));
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    RST = 1'b0;
    @(negedge CLK); #1;
    chk("run_idle", 32'(ctl), 32'(C_ALL));

    // dcache miss for three cycles
    @(negedge CLK); dren_m = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dstall", 32'(ctl), 32'(C_DSTALL));
      @(negedge CLK);
    end
    dhit = 1'b1; #1;
    chk("dstall_release", 32'(ctl), 32'(C_ALL));
    chk("stall_cnt_dstall", 32'(stall_cnt), 3);
    dren_m = 1'b0;

    // load-use on rt, then ex_rt=0, then rs match, then non-load
    @(negedge CLK); ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; #1;
    chk("lu_rt", 32'(ctl), 32'(C_LU));
    @(negedge CLK);
    chk("stall_cnt_lu", 32'(stall_cnt), 4);
    ex_rt = 5'd0; #1;
    chk("lu_zero_reg", 32'(ctl), 32'(C_ALL));
    @(negedge CLK); ex_rt = 5'd7; id_rs = 5'd7; id_rt = 5'd3; #1;
    chk("lu_rs", 32'(ctl), 32'(C_LU));
    @(negedge CLK); ex_memread = 1'b0; #1;
    chk("no_load_no_lu", 32'(ctl), 32'(C_ALL));
    chk("stall_cnt_lu2", 32'(stall_cnt), 5);

    // redirect with icache miss, then redirect with dcache miss
    @(negedge CLK); ex_rt = '0; id_rs = '0; id_rt = '0; redirect_ex = 1'b1; ihit = 1'b0; #1;
    chk("redirect_istall", 32'(ctl), 32'(C_REDIR));
    @(negedge CLK);
    chk("flush_cnt_1", 32'(flush_cnt), 1);
    chk("stall_cnt_redir", 32'(stall_cnt), 5);
    ihit = 1'b1; dren_m = 1'b1; dhit = 1'b0; #1;
    chk("redir_dstall", 32'(ctl), 32'(C_DSTALL));
    @(negedge CLK);
    chk("flush_cnt_held", 32'(flush_cnt), 1);
    chk("stall_cnt_rd", 32'(stall_cnt), 6);
    redirect_ex = 1'b0; dren_m = 1'b0; dhit = 1'b1; ihit = 1'b0; #1;
    chk("istall", 32'(ctl), 32'(C_ISTALL));
    @(negedge CLK);
    chk("stall_cnt_is", 32'(stall_cnt), 7);

    // halt drain into HALTED
    ihit = 1'b1; halt_id = 1'b1; #1;
    chk("halt_id_run", 32'(ctl), 32'(C_ALL));
    @(negedge CLK); halt_id = 1'b0; #1;
    chk("drain_1", 32'(ctl), 32'(C_DRAIN));
    @(negedge CLK); #1;
    chk("drain_2", 32'(ctl), 32'(C_DRAIN));
    chk("stall_cnt_drain", 32'(stall_cnt), 7);
    @(negedge CLK); halt_wb = 1'b1; #1;
    chk("drain_3_wb", 32'(ctl), 32'(C_DRAIN));
    @(negedge CLK); halt_wb = 1'b0; redirect_ex = 1'b1; ihit = 1'b0; #1;
    chk("halted", 32'(ctl), 32'(C_HALTED));
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      chk("halted_hold", 32'(ctl), 32'(C_HALTED));
      chk("halted_stall_cnt", 32'(stall_cnt), 7);
      chk("halted_flush_cnt", 32'(flush_cnt), 1);
    end

    // asynchronous reset mid-HALTED
    RST = 1'b1; redirect_ex = 1'b0; ihit = 1'b1; #1;
    chk("rst_from_halted", 32'(ctl), 32'(C_ALL));
    chk("rst_async_stall", 32'(stall_cnt), 0);
    chk("rst_async_flush", 32'(flush_cnt), 0);

    // wrong-path halt: drain then redirect
    @(negedge CLK); RST = 1'b0; halt_id = 1'b1; #1;
    chk("halt_id_2", 32'(ctl), 32'(C_ALL));
    @(negedge CLK); halt_id = 1'b0; ihit = 1'b0; #1;
    chk("drain_istall", 32'(ctl), 32'(C_DRAIN));
    @(negedge CLK);
    chk("stall_cnt_drain2", 32'(stall_cnt), 0);
    redirect_ex = 1'b1; #1;
    chk("drain_redirect", 32'(ctl), 32'(C_REDIR));
    @(negedge CLK); redirect_ex = 1'b0; ihit = 1'b1; #1;
    chk("back_to_run", 32'(ctl), 32'(C_ALL));
    chk("flush_cnt_drain", 32'(flush_cnt), 1);

    // stall counter saturation
    ihit = 1'b0;
    repeat (20) @(negedge CLK);
    #1;
    chk("stall_cnt_sat", 32'(stall_cnt), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
